// File: rtl/stream_mux_sel_fifo_if.sv
// Select-push channel from the AW arbiter into the W-channel ordering FIFO.
interface stream_mux_sel_fifo_if #(
  parameter int unsigned LOG_N_INP = 1
);
  logic                 sel_valid;
  logic [LOG_N_INP-1:0] sel;
  logic                 sel_ready;

  modport master (output sel_valid, sel, input sel_ready);
  modport slave  (input sel_valid, sel, output sel_ready);
endinterface

// File: rtl/stream_mux_sel_fifo.sv
// W-channel ordering controller: queues granted input indices, drives the mux
// select from the head and gates the mux output until a burst is outstanding.
module stream_mux_sel_fifo #(
  parameter int unsigned N_INP     = 2,
  parameter int unsigned LOG_N_INP = (N_INP > 1) ? $clog2(N_INP) : 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  stream_mux_sel_fifo_if.slave         sel_if,
  output logic [LOG_N_INP-1:0]         mux_sel_o,
  input  logic                         mux_valid_i,
  input  logic                         mux_last_i,
  output logic                         mux_ready_o,
  output logic                         oup_valid_o,
  input  logic                         oup_ready_i,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic [CNT_W-1:0]             beat_cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned USE_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [USE_W-1:0] use_t;

  logic [LOG_N_INP-1:0] mem_q [DEPTH];
  ptr_t                 wptr_q, wptr_d;
  ptr_t                 rptr_q, rptr_d;
  use_t                 count_q, count_d;
  logic [CNT_W-1:0]     beat_q, beat_d;

  logic not_empty, push, beat_hs, pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign not_empty        = (count_q != '0);
  assign sel_if.sel_ready = (count_q < use_t'(DEPTH)) && !flush_i;
  assign push             = sel_if.sel_valid && sel_if.sel_ready;
  assign beat_hs          = mux_valid_i && oup_ready_i && not_empty;
  assign pop              = beat_hs && mux_last_i;

  // Empty FIFO forces a zero select and blocks the handshake in both directions.
  assign mux_sel_o   = not_empty ? mem_q[rptr_q] : '0;
  assign oup_valid_o = not_empty && mux_valid_i;
  assign mux_ready_o = not_empty && oup_ready_i;
  assign busy_o      = not_empty;
  assign usage_o     = count_q;
  assign beat_cnt_o  = beat_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no latch is inferred.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    beat_d  = beat_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      beat_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      count_d = count_q + use_t'(1);
      else if (pop && !push) count_d = count_q - use_t'(1);
      if (pop)                            beat_d = '0;
      else if (beat_hs && (beat_q != '1)) beat_d = beat_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: storage is not reset; entries are only read while count_q marks them valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= sel_if.sel;
  end

endmodule
